// File: rtl/data_mem_ctrl.sv
// Data memory controller: word-organised synchronous RAM, read-modify-write sub-word stores,
// lane-extracted sign/zero-extended loads. Optional LED register enabled by DATA_MEM_LED_EN.
module data_mem_ctrl #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] LED_ADDR   = 32'h0000_2000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic        w_ena_i,
    input  logic        r_ena_i,
    input  logic [3:0]  sign_mask_i,
    output logic [31:0] data_o,
    output logic        busy_o,
    output logic        misalign_o,
    output logic [7:0]  led_o
);

    typedef enum logic [1:0] {IDLE, RD, RMW_RD, RMW_WR} state_t;

    localparam logic [2:0] SZ_B = 3'b001;
    localparam logic [2:0] SZ_H = 3'b011;
    localparam logic [2:0] SZ_W = 3'b111;

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] lane,
                                            input logic [3:0] m);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (m[2:0])
            SZ_B:    extract = m[3] ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_H:    extract = m[3] ? {16'h0, h} : {{16{h[15]}}, h};
            default: extract = w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                          input logic [1:0] lane, input logic [3:0] m);
        merge = w;
        case (m[2:0])
            SZ_B: merge[{lane, 3'b000} +: 8] = d[7:0];
            SZ_H: if (lane[1]) merge[31:16] = d[15:0];
                  else         merge[15:0]  = d[15:0];
            default: merge = d;
        endcase
    endfunction

    state_t                state;
    logic [31:0]           mem [2**ADDR_WIDTH];
    logic [31:0]           ram_q;
    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] cap_idx;
    logic [ADDR_WIDTH-1:0] ram_widx;
    logic [1:0]            cap_lane;
    logic [31:0]           cap_data;
    logic [3:0]            cap_mask;
    logic                  pend;
    logic [2:0]            size;
    logic                  req;
    logic                  misal;
    logic                  hit_led;
    logic                  word_st;
    logic                  ram_we;
    logic [31:0]           ram_wdata;
    logic [31:0]           load_val;

    assign size = sign_mask_i[2:0];
    assign idx  = addr_i[ADDR_WIDTH+1:2];
    assign req  = w_ena_i | r_ena_i;

    always_comb begin
        misal = 1'b0;
        if (size != SZ_B && size != SZ_H && size != SZ_W) misal = 1'b1;
        if (size == SZ_H && addr_i[0])                    misal = 1'b1;
        if (size == SZ_W && addr_i[1:0] != 2'b00)         misal = 1'b1;
    end

    // Reset gates the RAM write so an abort in RMW_WR never lands the merged word.
    assign word_st   = (state == IDLE) && w_ena_i && !misal && (size == SZ_W) && !hit_led;
    assign ram_we    = !reset_i && (word_st || state == RMW_WR);
    assign ram_widx  = (state == RMW_WR) ? cap_idx : idx;
    assign ram_wdata = (state == RMW_WR) ? merge(ram_q, cap_data, cap_lane, cap_mask) : data_i;
    assign busy_o    = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (ram_we) mem[ram_widx] <= ram_wdata;
        ram_q <= mem[cap_idx];
    end

`ifdef DATA_MEM_LED_EN
    logic [7:0] led_q;
    logic       cap_led;

    assign hit_led  = (addr_i[31:2] == LED_ADDR[31:2]);
    assign led_o    = led_q;
    assign load_val = cap_led ? {24'h0, led_q} : extract(ram_q, cap_lane, cap_mask);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            led_q   <= '0;
            cap_led <= 1'b0;
        end else if (state == IDLE && req && !misal) begin
            cap_led <= hit_led;
            if (w_ena_i && hit_led) led_q <= data_i[7:0];
        end
    end
`else
    logic unused_led;

    assign hit_led    = 1'b0;
    assign led_o      = '0;
    assign load_val   = extract(ram_q, cap_lane, cap_mask);
    assign unused_led = &{1'b0, addr_i[31:ADDR_WIDTH+2], LED_ADDR};
`endif

    // Load result lands one edge after RD, once ram_q holds the addressed word.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state      <= IDLE;
            data_o     <= '0;
            misalign_o <= 1'b0;
            pend       <= 1'b0;
            cap_idx    <= '0;
            cap_lane   <= '0;
            cap_data   <= '0;
            cap_mask   <= '0;
        end else begin
            misalign_o <= 1'b0;
            pend       <= 1'b0;
            if (pend) data_o <= load_val;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (misal) begin
                            misalign_o <= 1'b1;
                        end else if (!w_ena_i || (size != SZ_W && !hit_led)) begin
                            cap_idx  <= idx;
                            cap_lane <= addr_i[1:0];
                            cap_data <= data_i;
                            cap_mask <= sign_mask_i;
                            state    <= w_ena_i ? RMW_RD : RD;
                        end
                    end
                end
                RD: begin
                    pend  <= 1'b1;
                    state <= IDLE;
                end
                RMW_RD:  state <= RMW_WR;
                RMW_WR:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl; expected values are hand-computed.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic        w_ena_i;
    logic        r_ena_i;
    logic [3:0]  sign_mask_i;
    logic [31:0] data_o;
    logic        busy_o;
    logic        misalign_o;
    logic [7:0]  led_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDR_WIDTH(10), .LED_ADDR(32'h0000_2000)) dut (
        .clk_i(clk), .reset_i(reset_i), .addr_i(addr_i), .data_i(data_i),
        .w_ena_i(w_ena_i), .r_ena_i(r_ena_i), .sign_mask_i(sign_mask_i),
        .data_o(data_o), .busy_o(busy_o), .misalign_o(misalign_o), .led_o(led_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request before an edge and drop the enables just after it.
    task automatic issue(input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        w_ena_i = w; r_ena_i = r; addr_i = a; data_i = d; sign_mask_i = m;
        @(posedge clk); #1;
        w_ena_i = 1'b0; r_ena_i = 1'b0;
    endtask

    task automatic store(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m, input int busy_cycles);
        issue(1'b1, 1'b0, a, d, m);
        for (int i = 0; i < busy_cycles; i++) begin
            chk({tag, "_busy"}, 32'(busy_o), 32'd1);
            @(posedge clk); #1;
        end
        chk({tag, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    task automatic load(input string tag, input logic [31:0] a, input logic [3:0] m,
                        input logic [31:0] exp);
        issue(1'b0, 1'b1, a, 32'h0, m);
        chk({tag, "_busy"}, 32'(busy_o), 32'd1);
        @(posedge clk); #1;
        chk({tag, "_free"}, 32'(busy_o), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_data"}, data_o, exp);
    endtask

    task automatic reject(input string tag, input logic w, input logic [31:0] a,
                          input logic [3:0] m);
        issue(w, !w, a, 32'h5555_5555, m);
        chk({tag, "_mis"}, 32'(misalign_o), 32'd1);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_mis_end"}, 32'(misalign_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_i = 1'b0; w_ena_i = 1'b0; r_ena_i = 1'b0;
        addr_i = '0; data_i = '0; sign_mask_i = '0;
        #1 reset_i = 1'b1;
        #20;
        chk("rst_data", data_o, 32'h0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_mis", 32'(misalign_o), 32'd0);
        chk("rst_led", 32'(led_o), 32'd0);
        @(negedge clk) reset_i = 1'b0;

        // Word store then word load
        store("sw10", 32'h10, 32'hDEAD_BEEF, 4'b0111, 0);
        load("lw10", 32'h10, 4'b0111, 32'hDEAD_BEEF);
        store("sw00", 32'h00, 32'hCAFE_F00D, 4'b0111, 0);

        // Byte RMW and sign/zero extension
        store("sw10b", 32'h10, 32'h1122_3344, 4'b0111, 0);
        store("sb11", 32'h11, 32'h0000_0080, 4'b0001, 2);
        load("lw10m", 32'h10, 4'b0111, 32'h1122_8044);
        load("lb11", 32'h11, 4'b0001, 32'hFFFF_FF80);
        load("lbu11", 32'h11, 4'b1001, 32'h0000_0080);
        load("lb13", 32'h13, 4'b0001, 32'h0000_0011);
        load("lw_wrap", 32'h1010, 4'b0111, 32'h1122_8044);

        // Half RMW, upper lane, data upper bits must be ignored
        store("sw20", 32'h20, 32'h0, 4'b0111, 0);
        store("sh22", 32'h22, 32'hFFFF_BEEF, 4'b0011, 2);
        load("lw20", 32'h20, 4'b0111, 32'hBEEF_0000);
        load("lh22", 32'h22, 4'b0011, 32'hFFFF_BEEF);
        load("lhu22", 32'h22, 4'b1011, 32'h0000_BEEF);
        load("lh20", 32'h20, 4'b0011, 32'h0000_0000);
        load("lhu22b", 32'h22, 4'b1011, 32'h0000_BEEF);

        // Rejections leave data_o and RAM untouched
        reject("lw13", 1'b0, 32'h13, 4'b0111);
        reject("sh01", 1'b1, 32'h01, 4'b0011);
        reject("badmask", 1'b0, 32'h10, 4'b0101);
        reject("sw12", 1'b1, 32'h12, 4'b0111);
        chk("rej_data_hold", data_o, 32'h0000_BEEF);
        load("lw00", 32'h00, 4'b0111, 32'hCAFE_F00D);
        load("lw10r", 32'h10, 4'b0111, 32'h1122_8044);

        // Reset during RMW_WR aborts the store
        store("sw20c", 32'h20, 32'h0102_0304, 4'b0111, 0);
        issue(1'b1, 1'b0, 32'h20, 32'h0000_00AA, 4'b0001);
        @(posedge clk); #1;
        chk("rmw_wr_busy", 32'(busy_o), 32'd1);
        #2 reset_i = 1'b1;
        #1;
        chk("abort_data", data_o, 32'h0);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_mis", 32'(misalign_o), 32'd0);
        @(negedge clk); @(negedge clk) reset_i = 1'b0;
        load("lw20a", 32'h20, 4'b0111, 32'h0102_0304);

        // Both enables: store wins, load dropped
        issue(1'b1, 1'b1, 32'h24, 32'h7766_5544, 4'b0111);
        chk("both_busy", 32'(busy_o), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("both_data_hold", data_o, 32'h0102_0304);
        load("lw24", 32'h24, 4'b0111, 32'h7766_5544);

        // LED address decode
`ifdef DATA_MEM_LED_EN
        store("sb_led", 32'h2000, 32'h0000_005A, 4'b0001, 0);
        chk("led_val", 32'(led_o), 32'h5A);
        load("lw_led", 32'h2000, 4'b0111, 32'h0000_005A);
        load("lw00_led", 32'h00, 4'b0111, 32'hCAFE_F00D);
`else
        store("sb_led", 32'h2000, 32'h0000_005A, 4'b0001, 2);
        chk("led_val", 32'(led_o), 32'h0);
        load("lw_led", 32'h2000, 4'b0111, 32'hCAFE_F05A);
        load("lw00_led", 32'h00, 4'b0111, 32'hCAFE_F05A);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
